// File: rtl/pwm_sequencer_pkg.sv
// Shared types and constants for the PWM run sequencer.
// Holds the FSM state encoding and the counter mode codes.
package pwm_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STAGGER,
        RUNNING,
        DRAIN,
        RESTART
    } seq_state_t;

    localparam logic [1:0] MODE_DOWN   = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;

endpackage

// File: rtl/phase_stagger_timer.sv
// Counts timebase pulses while enabled and emits a one-clock tick every
// `step` pulses, reloading itself; held at zero while disabled.
module phase_stagger_timer #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     timebase,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] step,
    output logic                     tick
);

    logic [COUNTER_WIDTH-1:0] count_q;

    // A zero step never ticks; the sequencer launches all chains at once instead.
    assign tick = enable && timebase && (step != '0) &&
                  (count_q == step - COUNTER_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else if (timebase) begin
            count_q <= count_q + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_run_sequencer.sv
// Run/config sequencer for a bank of PWM counters: staggered start, boundary
// stop, and boundary-aligned stop/resync/restart to apply new limits.
module pwm_run_sequencer
    import pwm_sequencer_pkg::*;
#(
    parameter int N_CHAINS      = 3,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     timebase,
    input  logic                     start_req,
    input  logic                     stop_req,
    input  logic                     shadow_wr,
    input  logic [COUNTER_WIDTH-1:0] shadow_start,
    input  logic [COUNTER_WIDTH-1:0] shadow_stop,
    input  logic [1:0]               shadow_mode,
    input  logic [COUNTER_WIDTH-1:0] phase_step,
    input  logic [N_CHAINS-1:0]      reload_compare,
    output logic [N_CHAINS-1:0]      run,
    output logic                     sync,
    output logic [COUNTER_WIDTH-1:0] counter_start_data,
    output logic [COUNTER_WIDTH-1:0] counter_stop_data,
    output logic [1:0]               mode,
    output logic                     busy,
    output logic                     update_pending
);

    seq_state_t               state_q, state_d;
    logic [N_CHAINS-1:0]      run_d, run_shifted, launch_run;
    logic                     sync_d, apply, launch_full, tick, boundary;
    logic                     restart_ph_q, restart_ph_d, stop_seen_q, stop_seen_d;
    logic                     rc0_p1;
    logic [COUNTER_WIDTH-1:0] shadow_start_q, shadow_stop_q;
    logic [1:0]               shadow_mode_q;
    logic                     unused_rc;

    assign unused_rc   = ^reload_compare;
    assign boundary    = reload_compare[0] && !rc0_p1;
    assign busy        = (state_q != IDLE);
    assign launch_full = (phase_step == '0) || (N_CHAINS == 1);
    assign launch_run  = launch_full ? '1 : N_CHAINS'(1);
    assign run_shifted = (run << 1) | N_CHAINS'(1);

    phase_stagger_timer #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .timebase (timebase),
        .enable   ((state_q == STAGGER) && run[0]),
        .step     (phase_step),
        .tick     (tick)
    );

    always_comb begin
        state_d      = state_q;
        run_d        = run;
        sync_d       = 1'b0;
        apply        = 1'b0;
        restart_ph_d = restart_ph_q;
        stop_seen_d  = stop_seen_q;
        case (state_q)
            IDLE: begin
                if (start_req && !stop_req) begin
                    apply   = 1'b1;
                    state_d = STAGGER;
                end
            end
            STAGGER: begin
                if (stop_req) begin
                    state_d = DRAIN;
                end else if (!run[0]) begin
                    // First stagger cycle: release chain 0 together with the resync pulse.
                    sync_d = 1'b1;
                    run_d  = launch_run;
                    if (launch_full) state_d = RUNNING;
                end else if (tick) begin
                    run_d = run_shifted;
                    if (run_shifted[N_CHAINS-1]) state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (stop_req) begin
                    state_d = DRAIN;
                end else if (update_pending && boundary) begin
                    run_d        = '0;
                    restart_ph_d = 1'b0;
                    stop_seen_d  = 1'b0;
                    state_d      = RESTART;
                end
            end
            DRAIN: begin
                if (!run[0] || boundary) begin
                    run_d   = '0;
                    state_d = IDLE;
                end
            end
            RESTART: begin
                if (!restart_ph_q) begin
                    apply        = 1'b1;
                    sync_d       = 1'b1;
                    restart_ph_d = 1'b1;
                    stop_seen_d  = stop_req;
                end else if (stop_seen_q || stop_req) begin
                    state_d = IDLE;
                end else begin
                    run_d   = launch_run;
                    state_d = launch_full ? RUNNING : STAGGER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q            <= IDLE;
            run                <= '0;
            sync               <= 1'b0;
            restart_ph_q       <= 1'b0;
            stop_seen_q        <= 1'b0;
            rc0_p1             <= 1'b1;
            shadow_start_q     <= '0;
            shadow_stop_q      <= '0;
            shadow_mode_q      <= MODE_DOWN;
            counter_start_data <= '0;
            counter_stop_data  <= '0;
            mode               <= MODE_UP;
            update_pending     <= 1'b0;
        end else begin
            state_q      <= state_d;
            run          <= run_d;
            sync         <= sync_d;
            restart_ph_q <= restart_ph_d;
            stop_seen_q  <= stop_seen_d;
            rc0_p1       <= reload_compare[0];
            // The apply path reads the old shadow, so a same-clock write stays pending.
            if (shadow_wr) begin
                shadow_start_q <= shadow_start;
                shadow_stop_q  <= shadow_stop;
                shadow_mode_q  <= shadow_mode;
            end
            if (apply) begin
                counter_start_data <= shadow_start_q;
                counter_stop_data  <= shadow_stop_q;
                mode               <= shadow_mode_q;
            end
            if (shadow_wr)  update_pending <= 1'b1;
            else if (apply) update_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_run_sequencer.sv
// Directed bench for pwm_run_sequencer: stagger, boundary update, stop,
// priorities, zero step, mid-run reset and last-write-wins shadow.
module tb_pwm_run_sequencer;

    logic        clock = 1'b0;
    logic        reset, timebase, start_req, stop_req, shadow_wr;
    logic [15:0] shadow_start, shadow_stop, phase_step;
    logic [1:0]  shadow_mode;
    logic [2:0]  reload_compare;
    logic [2:0]  run;
    logic        sync, busy, update_pending;
    logic [15:0] counter_start_data, counter_stop_data;
    logic [1:0]  mode;
    int          checks = 0;
    int          errors = 0;

    pwm_run_sequencer #(.N_CHAINS(3), .COUNTER_WIDTH(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .timebase           (timebase),
        .start_req          (start_req),
        .stop_req           (stop_req),
        .shadow_wr          (shadow_wr),
        .shadow_start       (shadow_start),
        .shadow_stop        (shadow_stop),
        .shadow_mode        (shadow_mode),
        .phase_step         (phase_step),
        .reload_compare     (reload_compare),
        .run                (run),
        .sync               (sync),
        .counter_start_data (counter_start_data),
        .counter_stop_data  (counter_stop_data),
        .mode               (mode),
        .busy               (busy),
        .update_pending     (update_pending)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start_req = 1'b1; tick(); start_req = 1'b0;
    endtask

    task automatic stop_at_boundary();
        reload_compare = 3'b000; tick();
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        reload_compare = 3'b111; tick();
    endtask

    task automatic test_reset();
        checks++; if (run !== 3'b000) begin errors++; $display("FAIL rst_run got %b exp 000", run); end
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL rst_sync got %b exp 0", sync); end
        checks++; if (counter_stop_data !== 16'd0) begin errors++; $display("FAIL rst_stop got %0d exp 0", counter_stop_data); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL rst_mode got %0d exp 1", mode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL rst_pend got %b exp 0", update_pending); end
    endtask

    task automatic test_stagger();
        phase_step = 16'd4;
        pulse_start();
        checks++; if (busy !== 1'b1 || run !== 3'b000) begin errors++; $display("FAIL stg_e0 got busy=%b run=%b exp 1/000", busy, run); end
        tick();
        checks++; if (run !== 3'b001 || sync !== 1'b1) begin errors++; $display("FAIL stg_e1 got run=%b sync=%b exp 001/1", run, sync); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL stg_mode got %0d exp 0", mode); end
        tick();
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL stg_sync_e2 got %b exp 0", sync); end
        tick(); tick();
        checks++; if (run !== 3'b001) begin errors++; $display("FAIL stg_e4 got %b exp 001", run); end
        tick();
        checks++; if (run !== 3'b011) begin errors++; $display("FAIL stg_e5 got %b exp 011", run); end
        repeat (3) tick();
        checks++; if (run !== 3'b011) begin errors++; $display("FAIL stg_e8 got %b exp 011", run); end
        tick();
        checks++; if (run !== 3'b111) begin errors++; $display("FAIL stg_e9 got %b exp 111", run); end
    endtask

    task automatic test_update();
        reload_compare = 3'b000; tick();
        shadow_start = 16'd0; shadow_stop = 16'd49; shadow_mode = 2'd1;
        shadow_wr = 1'b1; tick(); shadow_wr = 1'b0;
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL upd_pend got %b exp 1", update_pending); end
        checks++; if (counter_stop_data !== 16'd0 || run !== 3'b111) begin errors++; $display("FAIL upd_hold got stop=%0d run=%b exp 0/111", counter_stop_data, run); end
        tick(); tick();
        reload_compare = 3'b111; tick();
        checks++; if (run !== 3'b000 || sync !== 1'b0 || counter_stop_data !== 16'd0) begin errors++; $display("FAIL upd_r1 got run=%b sync=%b stop=%0d exp 000/0/0", run, sync, counter_stop_data); end
        tick();
        checks++; if (sync !== 1'b1 || counter_stop_data !== 16'd49 || counter_start_data !== 16'd0) begin errors++; $display("FAIL upd_r2 got sync=%b stop=%0d start=%0d exp 1/49/0", sync, counter_stop_data, counter_start_data); end
        checks++; if (update_pending !== 1'b0 || run !== 3'b000 || mode !== 2'd1) begin errors++; $display("FAIL upd_r2b got pend=%b run=%b mode=%0d exp 0/000/1", update_pending, run, mode); end
        tick();
        checks++; if (run !== 3'b001 || sync !== 1'b0) begin errors++; $display("FAIL upd_s0 got run=%b sync=%b exp 001/0", run, sync); end
        repeat (3) tick();
        checks++; if (run !== 3'b001) begin errors++; $display("FAIL upd_s3 got %b exp 001", run); end
        tick();
        checks++; if (run !== 3'b011) begin errors++; $display("FAIL upd_s4 got %b exp 011", run); end
        repeat (4) tick();
        checks++; if (run !== 3'b111) begin errors++; $display("FAIL upd_s8 got %b exp 111", run); end
    endtask

    task automatic test_stop();
        reload_compare = 3'b000; tick();
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        checks++; if (run !== 3'b111 || busy !== 1'b1) begin errors++; $display("FAIL stop_drain got run=%b busy=%b exp 111/1", run, busy); end
        tick(); tick();
        checks++; if (run !== 3'b111) begin errors++; $display("FAIL stop_hold got %b exp 111", run); end
        reload_compare = 3'b111; tick();
        checks++; if (run !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL stop_drop got run=%b busy=%b exp 000/0", run, busy); end
        tick();
        checks++; if (busy !== 1'b0 || run !== 3'b000) begin errors++; $display("FAIL stop_idle got busy=%b run=%b exp 0/000", busy, run); end
    endtask

    task automatic test_priority();
        start_req = 1'b1; stop_req = 1'b1; tick(); start_req = 1'b0; stop_req = 1'b0;
        checks++; if (busy !== 1'b0 || run !== 3'b000) begin errors++; $display("FAIL pri_both got busy=%b run=%b exp 0/000", busy, run); end
        tick();
        checks++; if (busy !== 1'b0 || sync !== 1'b0) begin errors++; $display("FAIL pri_both2 got busy=%b sync=%b exp 0/0", busy, sync); end
        pulse_start();
        repeat (9) tick();
        checks++; if (run !== 3'b111) begin errors++; $display("FAIL pri_run got %b exp 111", run); end
        pulse_start();
        checks++; if (run !== 3'b111 || busy !== 1'b1 || sync !== 1'b0) begin errors++; $display("FAIL pri_ign got run=%b busy=%b sync=%b exp 111/1/0", run, busy, sync); end
        tick();
        checks++; if (sync !== 1'b0 || run !== 3'b111) begin errors++; $display("FAIL pri_ign2 got sync=%b run=%b exp 0/111", sync, run); end
        stop_at_boundary();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pri_stop got busy=%b exp 0", busy); end
    endtask

    task automatic test_phase0_reset();
        phase_step = 16'd0;
        pulse_start();
        checks++; if (run !== 3'b000) begin errors++; $display("FAIL p0_e0 got %b exp 000", run); end
        tick();
        checks++; if (run !== 3'b111 || sync !== 1'b1) begin errors++; $display("FAIL p0_e1 got run=%b sync=%b exp 111/1", run, sync); end
        stop_at_boundary();
        checks++; if (busy !== 1'b0 || run !== 3'b000) begin errors++; $display("FAIL p0_stop got busy=%b run=%b exp 0/000", busy, run); end
        phase_step = 16'd4;
        shadow_start = 16'd3; shadow_stop = 16'd40; shadow_mode = 2'd2;
        shadow_wr = 1'b1; tick();
        shadow_stop = 16'd77; shadow_mode = 2'd0;
        start_req = 1'b1; tick(); start_req = 1'b0; shadow_wr = 1'b0;
        checks++; if (counter_stop_data !== 16'd40 || mode !== 2'd2) begin errors++; $display("FAIL wr_start got stop=%0d mode=%0d exp 40/2", counter_stop_data, mode); end
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL wr_start_pend got %b exp 1", update_pending); end
        tick(); tick();
        reset = 1'b0; tick();
        checks++; if (run !== 3'b000 || sync !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst got run=%b sync=%b busy=%b exp 000/0/0", run, sync, busy); end
        checks++; if (counter_stop_data !== 16'd0 || counter_start_data !== 16'd0 || mode !== 2'd1 || update_pending !== 1'b0) begin errors++; $display("FAIL mid_rst_cfg got start=%0d stop=%0d mode=%0d pend=%b exp 0/0/1/0", counter_start_data, counter_stop_data, mode, update_pending); end
        reset = 1'b1; tick();
    endtask

    task automatic test_last_write();
        phase_step = 16'd1;
        pulse_start();
        repeat (3) tick();
        checks++; if (run !== 3'b111 || counter_stop_data !== 16'd0) begin errors++; $display("FAIL lw_run got run=%b stop=%0d exp 111/0", run, counter_stop_data); end
        reload_compare = 3'b000; tick();
        shadow_start = 16'd5; shadow_mode = 2'd2;
        shadow_stop = 16'd80; shadow_wr = 1'b1; tick();
        shadow_stop = 16'd60; tick(); shadow_wr = 1'b0;
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL lw_pend got %b exp 1", update_pending); end
        reload_compare = 3'b111; tick();
        checks++; if (run !== 3'b000) begin errors++; $display("FAIL lw_drop got %b exp 000", run); end
        tick();
        checks++; if (counter_stop_data !== 16'd60 || counter_start_data !== 16'd5 || mode !== 2'd2) begin errors++; $display("FAIL lw_apply got stop=%0d start=%0d mode=%0d exp 60/5/2", counter_stop_data, counter_start_data, mode); end
        tick();
        checks++; if (run !== 3'b001) begin errors++; $display("FAIL lw_restart got %b exp 001", run); end
    endtask

    initial begin
        reset = 1'b0; timebase = 1'b1; start_req = 1'b0; stop_req = 1'b0; shadow_wr = 1'b0;
        shadow_start = '0; shadow_stop = '0; shadow_mode = '0; phase_step = '0;
        reload_compare = 3'b111;
        tick(); tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_stagger();
        test_update();
        test_stop();
        test_priority();
        test_phase0_reset();
        test_last_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
